// File: rtl/boreal_pkg.sv
// Shared definitions for the boreal channel sequencer: sample width,
// sequencer FSM states and the 16-bit saturation helper.
package boreal_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

  // Clamp a 32-bit signed value into the signed 16-bit range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/boreal_frame_fifo.sv
// Two-entry frame FIFO. The caller never pushes while full unless it pops
// in the same cycle; a simultaneous push/pop on a full FIFO overwrites the
// slot being read, which is safe because the read is combinational.
module boreal_frame_fifo #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q;

  // Storage has no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/boreal_channel_sequencer.sv
// Frame-to-serial channel sequencer: buffers parallel frames in a 2-entry
// FIFO and emits them one channel per sample, ch0 first, with optional idle
// gaps. Optional per-channel baseline removal under BOREAL_DC_REMOVE_EN.
module boreal_channel_sequencer
  import boreal_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int GAP_CYCLES = 0,
  parameter int DC_SHIFT   = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_valid,
  input  logic [N_CH*SAMPLE_W-1:0]     frame_data,
  output logic                         sample_valid,
  output logic signed [SAMPLE_W-1:0]   sample_out,
  output logic [$clog2(N_CH)-1:0]      sample_ch,
  output logic                         frame_last,
  output logic                         fifo_full,
  output logic [15:0]                  drop_count
);

  localparam int          CH_W   = $clog2(N_CH);
  localparam int          FW     = N_CH * SAMPLE_W;
  localparam logic [3:0]  GAP_M1 = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  seq_state_e              state_q;
  logic [CH_W-1:0]         ch_q;
  logic [3:0]              gap_q;
  logic [FW-SAMPLE_W-1:0]  frame_q;   // channels 1..N_CH-1 of the frame in flight

  logic                    sample_valid_q, frame_last_q, fifo_full_q;
  logic signed [SAMPLE_W-1:0] sample_out_q;
  logic [CH_W-1:0]         sample_ch_q;
  logic [15:0]             drop_q;

  logic [FW-1:0]           fifo_rdata;
  logic [1:0]              fifo_count, cnt_next;
  logic                    push, pop, drop, load, emit;
  logic signed [SAMPLE_W-1:0] frame_ch [N_CH];
  logic signed [SAMPLE_W-1:0] emit_x, out_val;

  boreal_frame_fifo #(.WIDTH(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (frame_data),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // ch0 comes straight from the FIFO head so the load cycle also emits it;
  // the remaining channels come from the latched frame.
  assign frame_ch[0] = fifo_rdata[SAMPLE_W-1:0];
  for (genvar g = 1; g < N_CH; g++) begin : g_ch
    assign frame_ch[g] = frame_q[(g-1)*SAMPLE_W +: SAMPLE_W];
  end

  // Emission control: a frame is loaded (and popped) only when starting at ch0.
  always_comb begin
    load     = (fifo_count != 2'd0) &&
               ((state_q == IDLE) || (state_q == EMIT && ch_q == '0));
    emit     = load || (state_q == EMIT && ch_q != '0);
    pop      = load;
    push     = frame_valid && ((fifo_count != 2'd2) || pop);
    drop     = frame_valid && (fifo_count == 2'd2) && !pop;
    cnt_next = fifo_count + {1'b0, push} - {1'b0, pop};
    emit_x   = frame_ch[ch_q];
  end

`ifdef BOREAL_DC_REMOVE_EN
  logic signed [31:0] base_q [N_CH];
  logic signed [31:0] x_ext, diff;

  // Subtract the pre-update baseline of the channel being emitted.
  always_comb begin
    x_ext   = {{16{emit_x[SAMPLE_W-1]}}, emit_x};
    diff    = x_ext - base_q[ch_q];
    out_val = sat16(diff);
  end

  // Leaky baseline tracker, one per channel, stepped on each emitted sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) base_q[i] <= '0;
    end else if (emit) begin
      base_q[ch_q] <= base_q[ch_q] + (diff >>> DC_SHIFT);
    end
  end
`else
  assign out_val = emit_x;
`endif

  // Sequencer FSM with registered outputs and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      gap_q          <= 4'd0;
      frame_q        <= '0;
      sample_valid_q <= 1'b0;
      sample_out_q   <= '0;
      sample_ch_q    <= '0;
      frame_last_q   <= 1'b0;
      fifo_full_q    <= 1'b0;
      drop_q         <= 16'd0;
    end else begin
      sample_valid_q <= emit;
      fifo_full_q    <= (cnt_next == 2'd2);
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (load) frame_q <= fifo_rdata[FW-1:SAMPLE_W];
      if (emit) begin
        sample_out_q <= out_val;
        sample_ch_q  <= ch_q;
        frame_last_q <= (ch_q == LAST_CH);
        ch_q         <= ch_q + 1'b1;   // wraps to 0 after the last channel
      end
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= (GAP_CYCLES > 0) ? GAP : EMIT;
            gap_q   <= GAP_M1;
          end
        end
        EMIT: begin
          if (emit) begin
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              gap_q   <= GAP_M1;
            end else if (ch_q == LAST_CH && fifo_count == 2'd0) begin
              state_q <= IDLE;
            end
          end else begin
            state_q <= IDLE;           // frame boundary reached with nothing queued
          end
        end
        GAP: begin
          if (gap_q == 4'd0) state_q <= EMIT;
          else               gap_q   <= gap_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_valid = sample_valid_q;
  assign sample_out   = sample_out_q;
  assign sample_ch    = sample_ch_q;
  assign frame_last   = frame_last_q;
  assign fifo_full    = fifo_full_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_boreal_channel_sequencer.sv
// Directed bench for boreal_channel_sequencer (default build, macro off):
// one instance with GAP_CYCLES=0 and one with GAP_CYCLES=2.
module tb_boreal_channel_sequencer;

  localparam int NC = 8;
  localparam int FW = NC * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, fv;
  logic [FW-1:0] fd;
  logic          sv, fl, ff;
  logic signed [15:0] so;
  logic [2:0]    sc;
  logic [15:0]   dc;

  logic          rst2_n, fv2;
  logic [FW-1:0] fd2;
  logic          sv2, fl2, ff2;
  logic signed [15:0] so2;
  logic [2:0]    sc2;
  logic [15:0]   dc2;

  boreal_channel_sequencer #(.N_CH(NC), .GAP_CYCLES(0), .DC_SHIFT(6)) uut (
    .clk(clk), .rst_n(rst_n), .frame_valid(fv), .frame_data(fd),
    .sample_valid(sv), .sample_out(so), .sample_ch(sc), .frame_last(fl),
    .fifo_full(ff), .drop_count(dc)
  );

  boreal_channel_sequencer #(.N_CH(NC), .GAP_CYCLES(2), .DC_SHIFT(6)) uut2 (
    .clk(clk), .rst_n(rst2_n), .frame_valid(fv2), .frame_data(fd2),
    .sample_valid(sv2), .sample_out(so2), .sample_ch(sc2), .frame_last(fl2),
    .fifo_full(ff2), .drop_count(dc2)
  );

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] val;
    logic        last;
  } vec_t;

  vec_t tbl [NC];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] mk_frame(input int base, input int step);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NC; i++) f[i*16 +: 16] = 16'(base + step * i);
    return f;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(sv), 32'd0);
    chk({tag, "_out"},   32'(so), 32'd0);
    chk({tag, "_ch"},    32'(sc), 32'd0);
    chk({tag, "_last"},  32'(fl), 32'd0);
    chk({tag, "_full"},  32'(ff), 32'd0);
    chk({tag, "_drop"},  32'(dc), 32'd0);
  endtask

  int got_v[$];
  int got_c[$];
  int got_t[$];

  initial begin
    int found, bad;
    rst_n = 1'b0; fv = 1'b0; fd = '0;
    rst2_n = 1'b0; fv2 = 1'b0; fd2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---- single frame, ch i = 100*i, table-driven ----
    for (int i = 0; i < NC; i++) tbl[i] = '{ch: 3'(i), val: 16'(100 * i), last: (i == NC - 1)};
    fd = mk_frame(0, 100); fv = 1'b1;                 // cycle k
    @(posedge clk); #1; fv = 1'b0;                    // cycle k+1
    @(negedge clk);
    chk("t1_k1_idle", 32'(sv), 32'd0);
    for (int i = 0; i < NC; i++) begin                // cycles k+2..k+9
      @(negedge clk);
      chk($sformatf("t1_valid%0d", i), 32'(sv), 32'd1);
      chk($sformatf("t1_ch%0d", i),    32'(sc), 32'(tbl[i].ch));
      chk($sformatf("t1_val%0d", i),   32'(so), 32'(tbl[i].val));
      chk($sformatf("t1_last%0d", i),  32'(fl), 32'(tbl[i].last));
    end
    @(negedge clk);
    chk("t1_after_valid", 32'(sv), 32'd0);
    chk("t1_hold_out",    32'(so), 32'd700);
    chk("t1_hold_ch",     32'(sc), 32'd7);

    // ---- overflow while busy: A, then B,C,D on consecutive cycles ----
    for (int n = 0; n < 44; n++) begin
      @(posedge clk); #1;
      fv = (n == 0) || (n >= 3 && n <= 5);
      fd = (n == 0) ? mk_frame(1000, 1) : mk_frame(1000 * (n - 1), 1);
      @(negedge clk);
      if (sv) begin got_v.push_back(int'(so)); got_c.push_back(int'(sc)); got_t.push_back(n); end
      if (n == 5) chk("t2_fifo_full", 32'(ff), 32'd1);
    end
    chk("t2_nsamples", 32'(got_v.size()), 32'd24);
    chk("t2_drop",     32'(dc), 32'd1);
    chk("t2_full_clr", 32'(ff), 32'd0);
    if (got_v.size() >= 24) begin
      for (int j = 0; j < 24; j++) begin
        chk($sformatf("t2_val%0d", j), 32'(got_v[j]), 32'(1000 * (j / 8 + 1) + j % 8));
        chk($sformatf("t2_ch%0d", j),  32'(got_c[j]), 32'(j % 8));
      end
      chk("t2_contig16", 32'(got_t[23] - got_t[8]), 32'd15);
    end

    // ---- reset on the ch3 sample with another frame queued ----
    @(posedge clk); #1; fd = mk_frame(50, 1); fv = 1'b1;
    @(posedge clk); #1; fd = mk_frame(9000, 1);
    @(posedge clk); #1; fv = 1'b0;
    found = 0;
    for (int w = 0; w < 20 && found == 0; w++) begin
      @(negedge clk);
      if (sv && sc == 3'd3) found = 1;
    end
    chk("t3_reached_ch3", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("t3_rst");
    @(negedge clk);
    chk_zero("t3_rst2");
    @(posedge clk); #1; rst_n = 1'b1;
    bad = 0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      if (sv !== 1'b0) bad++;
    end
    chk("t3_flushed", 32'(bad), 32'd0);
    @(posedge clk); #1; fd = mk_frame(500, 1); fv = 1'b1;
    @(posedge clk); #1; fv = 1'b0;
    found = 0;
    for (int w = 0; w < 10 && found == 0; w++) begin
      @(negedge clk);
      if (sv) found = 1;
    end
    chk("t3_first_valid", 32'(found), 32'd1);
    chk("t3_first_ch",    32'(sc), 32'd0);
    chk("t3_first_val",   32'(so), 32'd500);
    for (int i = 1; i < NC; i++) begin
      @(negedge clk);
      chk($sformatf("t3_ch%0d", i), {28'd0, sv, sc}, {28'd0, 1'b1, 3'(i)});
    end

    // ---- GAP_CYCLES=2 instance: two frames, spacing of 3 cycles ----
    got_v.delete(); got_c.delete(); got_t.delete();
    for (int n = 0; n < 64; n++) begin
      @(posedge clk); #1;
      fv2 = (n < 2);
      fd2 = mk_frame(100 * (n + 1), 1);
      @(negedge clk);
      if (sv2) begin got_v.push_back(int'(so2)); got_c.push_back(int'(sc2)); got_t.push_back(n); end
    end
    chk("t4_nsamples", 32'(got_v.size()), 32'd16);
    if (got_v.size() >= 16) begin
      chk("t4_latency", 32'(got_t[0]), 32'd2);
      for (int j = 0; j < 16; j++)
        chk($sformatf("t4_val%0d", j), 32'(got_v[j]), 32'(100 * (j / 8 + 1) + j % 8));
      for (int j = 1; j < 16; j++)
        chk($sformatf("t4_gap%0d", j), 32'(got_t[j] - got_t[j-1]), 32'd3);
    end

    // ---- drop counter saturation on the gapped instance ----
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk); #1;
      fv2 = 1'b1;
      fd2 = mk_frame(n, 1);
    end
    @(posedge clk); #1; fv2 = 1'b0;
    @(negedge clk);
    chk("t5_drop_sat", 32'(dc2), 32'h0000FFFF);
    chk("t5_full",     32'(ff2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
